seq_mem_ctrl: RTL and testbench

SEQ_MEM_CTRL -- requirements
Module: seq_mem_ctrl

---
 rtl/b12_pkg.sv | 18 +
 rtl/seq_mem_ctrl_if.sv | 47 ++++
 rtl/seq_ram.sv | 30 +++
 rtl/seq_mem_ctrl.sv | 164 ++++++++++++++++
 tb/tb_seq_mem_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/b12_pkg.sv
// Shared definitions for the sequence-memory controller.
// Holds the default geometry, the read latency and the controller state enum.
package b12_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 2;
  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam int unsigned READ_LAT = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD1   = 3'd1,
    RD2   = 3'd2,
    WR    = 3'd3,
    CLEAR = 3'd4
  } state_e;

endpackage

// File: rtl/seq_mem_ctrl_if.sv
// Two-requester memory bus plus clear/busy sideband.
// master: requesters (game FSM on port A, replay/debug on port B) drive
//         req/wr/addr/wdata and clr; they observe gnt/rvalid/rdata/busy.
// slave : the controller, with the opposite directions.
interface seq_mem_ctrl_if #(
  parameter int unsigned ADDR_W = b12_pkg::ADDR_W,
  parameter int unsigned DATA_W = b12_pkg::DATA_W
);

  logic              a_req;
  logic              a_wr;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_wr;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic              clr;
  logic              busy;

  modport master (
    output a_req, a_wr, a_addr, a_wdata,
    output b_req, b_wr, b_addr, b_wdata,
    output clr,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  busy
  );

  modport slave (
    input  a_req, a_wr, a_addr, a_wdata,
    input  b_req, b_wr, b_addr, b_wdata,
    input  clr,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output busy
  );

endinterface

// File: rtl/seq_ram.sv
// Sequence storage: DEPTH x DATA_W, one synchronous write port and a
// registered read port with one cycle of latency. Contents are not reset.
// Ports: clk_i, we_i/waddr_i/wdata_i (write), raddr_i/rdata_o (read).
module seq_ram #(
  parameter int unsigned ADDR_W = b12_pkg::ADDR_W,
  parameter int unsigned DATA_W = b12_pkg::DATA_W
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH_L = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH_L];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/seq_mem_ctrl.sv
// Round-robin two-port controller in front of the sequence RAM, with a
// whole-memory clear sequence.
// Ports: clock, reset (synchronous, active high), bus (slave modport:
//        port A/B request/grant/read-return, clr request, busy status).
module seq_mem_ctrl
  import b12_pkg::*;
#(
  parameter int unsigned ADDR_W = b12_pkg::ADDR_W,
  parameter int unsigned DATA_W = b12_pkg::DATA_W
) (
  input  logic          clock,
  input  logic          reset,
  seq_mem_ctrl_if.slave bus
);

  localparam int unsigned MEM_DEPTH = 2 ** ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              own_b_q, own_b_d;
  logic              last_b_q, last_b_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              busy_q;

  logic              a_gnt_c, b_gnt_c;
  logic              ram_we_c;
  logic [ADDR_W-1:0] ram_waddr_c;
  logic [DATA_W-1:0] ram_wdata_c;
  logic [DATA_W-1:0] ram_rdata;

  // The read port follows addr_d so a granted read is looked up at the grant
  // edge and the data is ready to register during RD1.
  seq_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (ram_we_c),
    .waddr_i (ram_waddr_c),
    .wdata_i (ram_wdata_c),
    .raddr_i (addr_d),
    .rdata_o (ram_rdata)
  );

  // Next-state, arbitration and RAM control.
  // The access direction is latched implicitly by choosing RD1 or WR.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    own_b_d     = own_b_q;
    last_b_d    = last_b_q;
    clr_addr_d  = clr_addr_q;
    a_gnt_c     = 1'b0;
    b_gnt_c     = 1'b0;
    a_rvalid_d  = 1'b0;
    b_rvalid_d  = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    ram_we_c    = 1'b0;
    ram_waddr_c = addr_q;
    ram_wdata_c = wdata_q;

    case (state_q)
      IDLE: begin
        if (!reset) begin
          if (bus.clr) begin
            state_d    = CLEAR;
            clr_addr_d = '0;
          end else if (bus.a_req && (!bus.b_req || last_b_q)) begin
            // A wins when alone or when B held the last grant.
            a_gnt_c  = 1'b1;
            own_b_d  = 1'b0;
            last_b_d = 1'b0;
            addr_d   = bus.a_addr;
            wdata_d  = bus.a_wdata;
            state_d  = bus.a_wr ? WR : RD1;
          end else if (bus.b_req) begin
            b_gnt_c  = 1'b1;
            own_b_d  = 1'b1;
            last_b_d = 1'b1;
            addr_d   = bus.b_addr;
            wdata_d  = bus.b_wdata;
            state_d  = bus.b_wr ? WR : RD1;
          end
        end
      end
      RD1: begin
        state_d = RD2;
        if (own_b_q) begin
          b_rvalid_d = 1'b1;
          b_rdata_d  = ram_rdata;
        end else begin
          a_rvalid_d = 1'b1;
          a_rdata_d  = ram_rdata;
        end
      end
      RD2: begin
        state_d = IDLE;
      end
      WR: begin
        ram_we_c = 1'b1;
        state_d  = IDLE;
      end
      CLEAR: begin
        ram_we_c    = 1'b1;
        ram_waddr_c = clr_addr_q;
        ram_wdata_c = '0;
        // Stop on the last address; the pointer is left there, not wrapped.
        if (clr_addr_q == ADDR_W'(MEM_DEPTH - 1)) begin
          state_d = IDLE;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      own_b_q    <= 1'b0;
      last_b_q   <= 1'b1;
      clr_addr_q <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      own_b_q    <= own_b_d;
      last_b_q   <= last_b_d;
      clr_addr_q <= clr_addr_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign bus.a_gnt    = a_gnt_c;
  assign bus.b_gnt    = b_gnt_c;
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_seq_mem_ctrl.sv
// Self-checking bench for seq_mem_ctrl: directed scenarios plus randomized
// traffic checked against a behavioural memory/arbitration model.
module tb_seq_mem_ctrl;
  import b12_pkg::*;

  localparam int unsigned AW = ADDR_W;
  localparam int unsigned DW = DATA_W;
  localparam int unsigned NW = DEPTH;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   errors = 0;

  logic [DW-1:0] mem_m [NW];
  bit            last_b_m;

  always #5 clk = ~clk;

  seq_mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  seq_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Grants must be exclusive and only appear while idle.
  always @(negedge clk) begin
    if (!reset && (bus.a_gnt === 1'b1 || bus.b_gnt === 1'b1)) begin
      tests++;
      if ((bus.a_gnt === 1'b1 && bus.b_gnt === 1'b1) || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL gnt_excl: a_gnt=%b b_gnt=%b busy=%b, want one gnt and busy=0",
                 bus.a_gnt, bus.b_gnt, bus.busy);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.a_req = 1'b0; bus.a_wr = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_wr = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    bus.clr   = 1'b0;
  endtask

  task automatic drive(input bit p, input bit req, input bit wr,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (p) begin
      bus.b_req = req; bus.b_wr = wr; bus.b_addr = addr; bus.b_wdata = wd;
    end else begin
      bus.a_req = req; bus.a_wr = wr; bus.a_addr = addr; bus.a_wdata = wd;
    end
  endtask

  function automatic logic gnt_of(input bit p);
    return p ? bus.b_gnt : bus.a_gnt;
  endfunction

  function automatic logic rvalid_of(input bit p);
    return p ? bus.b_rvalid : bus.a_rvalid;
  endfunction

  function automatic logic [DW-1:0] rdata_of(input bit p);
    return p ? bus.b_rdata : bus.a_rdata;
  endfunction

  // Waits (bounded) for a grant to port p; returns at the negedge of the grant cycle.
  task automatic wait_gnt(input bit p, output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gnt_of(p) === 1'b1) begin
        ok = 1'b1;
        waited = i;
        return;
      end
      tick();
    end
  endtask

  // Runs one access on port p and returns what the bus showed READ_LAT cycles
  // after the grant; ends just after the edge into the next idle cycle.
  task automatic do_op(input bit p, input bit wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, output bit ok, output int waited,
                       output logic rv, output logic [DW-1:0] rd, output logic orv);
    rv = 1'b0; rd = '0; orv = 1'b0;
    drive(p, 1'b1, wr, addr, wd);
    wait_gnt(p, ok, waited);
    tick();
    drive(p, 1'b0, 1'b0, '0, '0);
    if (!ok) return;
    if (wr) begin
      tick();
    end else begin
      for (int i = 1; i < int'(READ_LAT); i++) tick();
      @(negedge clk);
      rv  = rvalid_of(p);
      rd  = rdata_of(p);
      orv = rvalid_of(!p);
      tick();
    end
  endtask

  // Records the first n grants (port and cycle offset) while requests are held.
  task automatic collect_grants(input int n, output int port[4], output int gc[4],
                                output int got);
    got = 0;
    for (int i = 0; i < 4; i++) begin port[i] = -1; gc[i] = -1; end
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.a_gnt === 1'b1) begin port[got] = 0; gc[got] = c; got++; end
      else if (bus.b_gnt === 1'b1) begin port[got] = 1; gc[got] = c; got++; end
      if (got >= n) break;
      tick();
    end
    tick();
    quiet();
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    quiet();
    bus.a_req = 1'b1;
    bus.b_req = 1'b1;
    tick();
    tick();
    @(negedge clk);
    tests++; if (bus.a_gnt !== 1'b0) begin errors++; $display("FAIL reset_a_gnt: got %b want 0", bus.a_gnt); end
    tests++; if (bus.b_gnt !== 1'b0) begin errors++; $display("FAIL reset_b_gnt: got %b want 0", bus.b_gnt); end
    tests++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    tests++; if (bus.a_rvalid !== 1'b0 || bus.b_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b/%b want 0/0", bus.a_rvalid, bus.b_rvalid); end
    tests++; if (bus.a_rdata !== '0 || bus.b_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %0d/%0d want 0/0", bus.a_rdata, bus.b_rdata); end
    tick();
    quiet();
    tick();
    reset = 1'b0;
    last_b_m = 1'b1;
  endtask

  task automatic test_write_read();
    drive(1'b0, 1'b1, 1'b1, AW'(3), DW'(2));
    @(negedge clk);
    tests++; if (bus.a_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b want 1", bus.a_gnt); end
    tick();
    drive(1'b0, 1'b1, 1'b0, AW'(3), '0);
    @(negedge clk);
    tests++; if (bus.a_gnt !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL wr_busy: gnt=%b busy=%b want 0/1", bus.a_gnt, bus.busy); end
    tick();
    @(negedge clk);
    tests++; if (bus.a_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b want 1", bus.a_gnt); end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    tests++; if (bus.a_rvalid !== 1'b0) begin errors++; $display("FAIL rd_early: rvalid=%b want 0 one cycle after grant", bus.a_rvalid); end
    tick();
    @(negedge clk);
    tests++; if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== DW'(2) || bus.b_rvalid !== 1'b0) begin errors++; $display("FAIL rd_data: rvalid=%b rdata=%0d b_rvalid=%b want 1/2/0", bus.a_rvalid, bus.a_rdata, bus.b_rvalid); end
    tick();
    @(negedge clk);
    tests++; if (bus.a_rvalid !== 1'b0 || bus.a_rdata !== DW'(2)) begin errors++; $display("FAIL rd_hold: rvalid=%b rdata=%0d want 0/2", bus.a_rvalid, bus.a_rdata); end
    tick();
    mem_m[3] = DW'(2);
    last_b_m = 1'b0;
  endtask

  task automatic test_round_robin();
    int port[4];
    int gc[4];
    int got;
    bit exp;
    reset = 1'b1;
    quiet();
    drive(1'b0, 1'b1, 1'b0, AW'($urandom_range(0, NW - 1)), '0);
    drive(1'b1, 1'b1, 1'b0, AW'($urandom_range(0, NW - 1)), '0);
    tick();
    tick();
    reset = 1'b0;
    last_b_m = 1'b1;
    collect_grants(4, port, gc, got);
    tests++; if (got != 4 || gc[0] != 0) begin errors++; $display("FAIL rr_count: got %0d grants first at %0d, want 4 first at 0", got, gc[0]); end
    for (int i = 0; i < 4; i++) begin
      exp = last_b_m ? 1'b0 : 1'b1;
      last_b_m = exp;
      tests++; if (port[i] != int'(exp)) begin errors++; $display("FAIL rr_order[%0d]: got port %0d want %0d", i, port[i], exp); end
      if (i > 0) begin
        tests++; if (gc[i] - gc[i-1] != 3) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d cycles want 3", i, gc[i] - gc[i-1]); end
      end
    end
  endtask

  task automatic test_clear();
    bit ok;
    int waited;
    logic rv, orv;
    logic [DW-1:0] rd;
    int n;
    logic [AW-1:0] rd_addrs[3];
    rd_addrs[0] = AW'(0); rd_addrs[1] = AW'(17); rd_addrs[2] = AW'(31);
    for (int a = 0; a < int'(NW); a++) begin
      do_op(1'b0, 1'b1, AW'(a), DW'(1), ok, waited, rv, rd, orv);
      tests++; if (!ok || waited != 0) begin errors++; $display("FAIL fill_gnt[%0d]: ok=%b waited=%0d want 1/0", a, ok, waited); end
      mem_m[a] = DW'(1);
      last_b_m = 1'b0;
    end
    do_op(1'b1, 1'b0, AW'(17), '0, ok, waited, rv, rd, orv);
    tests++; if (rv !== 1'b1 || rd !== mem_m[17] || orv !== 1'b0) begin errors++; $display("FAIL fill_check: rvalid=%b rdata=%0d a_rvalid=%b want 1/%0d/0", rv, rd, orv, mem_m[17]); end
    last_b_m = 1'b1;
    bus.clr = 1'b1;
    @(negedge clk);
    tests++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clr_cycle_busy: got %b want 0", bus.busy); end
    tick();
    bus.clr = 1'b0;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) break;
      n++;
      tick();
    end
    tests++; if (n != int'(NW)) begin errors++; $display("FAIL clr_busy_len: got %0d cycles want %0d", n, NW); end
    tick();
    for (int a = 0; a < int'(NW); a++) mem_m[a] = '0;
    for (int k = 0; k < 3; k++) begin
      do_op(1'b0, 1'b0, rd_addrs[k], '0, ok, waited, rv, rd, orv);
      tests++; if (!ok || rv !== 1'b1 || rd !== mem_m[rd_addrs[k]]) begin errors++; $display("FAIL clr_read[%0d]: ok=%b rvalid=%b rdata=%0d want 1/1/%0d", rd_addrs[k], ok, rv, rd, mem_m[rd_addrs[k]]); end
      last_b_m = 1'b0;
    end
  endtask

  task automatic test_clr_priority();
    int w;
    bit found;
    drive(1'b0, 1'b1, 1'b0, AW'(5), '0);
    bus.clr = 1'b1;
    @(negedge clk);
    tests++; if (bus.a_gnt !== 1'b0 || bus.b_gnt !== 1'b0) begin errors++; $display("FAIL clr_pri_gnt: a_gnt=%b b_gnt=%b want 0/0", bus.a_gnt, bus.b_gnt); end
    tick();
    bus.clr = 1'b0;
    found = 1'b0;
    w = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.a_gnt === 1'b1) begin found = 1'b1; w = i; break; end
      tick();
    end
    tests++; if (!found || w != int'(NW) || bus.busy !== 1'b0) begin errors++; $display("FAIL clr_pri_after: found=%b at %0d busy=%b want 1 at %0d busy 0", found, w, bus.busy, NW); end
    tick();
    quiet();
    tick();
    @(negedge clk);
    tests++; if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== mem_m[5]) begin errors++; $display("FAIL clr_pri_read: rvalid=%b rdata=%0d want 1/%0d", bus.a_rvalid, bus.a_rdata, mem_m[5]); end
    tick();
    last_b_m = 1'b0;
  endtask

  task automatic test_reset_abort();
    bit ok;
    int waited;
    bit seen;
    logic busy_after;
    int port[4];
    int gc[4];
    int got;
    bit exp;
    drive(1'b0, 1'b1, 1'b0, AW'(7), '0);
    wait_gnt(1'b0, ok, waited);
    tests++; if (!ok) begin errors++; $display("FAIL abort_gnt: got no grant want grant"); end
    tick();
    quiet();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    last_b_m = 1'b1;
    seen = 1'b0;
    busy_after = 1'bx;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) busy_after = bus.busy;
      if (bus.a_rvalid !== 1'b0) seen = 1'b1;
      tick();
    end
    tests++; if (seen) begin errors++; $display("FAIL abort_rvalid: got a_rvalid pulse want none"); end
    tests++; if (busy_after !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy_after); end
    drive(1'b0, 1'b1, 1'b0, AW'(1), '0);
    drive(1'b1, 1'b1, 1'b0, AW'(2), '0);
    collect_grants(2, port, gc, got);
    tests++; if (got != 2) begin errors++; $display("FAIL abort_tie_count: got %0d grants want 2", got); end
    for (int i = 0; i < 2; i++) begin
      exp = last_b_m ? 1'b0 : 1'b1;
      last_b_m = exp;
      tests++; if (port[i] != int'(exp)) begin errors++; $display("FAIL abort_tie[%0d]: got port %0d want %0d", i, port[i], exp); end
    end
  endtask

  task automatic test_random();
    bit ok;
    int waited;
    logic rv, orv;
    logic [DW-1:0] rd;
    int mode;
    int n_ops;
    bit op_p[2];
    bit op_wr[2];
    logic [AW-1:0] op_addr[2];
    logic [DW-1:0] op_wd[2];
    logic [AW-1:0] addr_p[2];
    logic [DW-1:0] wd_p[2];
    bit wr_p[2];
    for (int it = 0; it < 40; it++) begin
      mode = int'($urandom_range(0, 2));
      for (int p = 0; p < 2; p++) begin
        wr_p[p]   = 1'($urandom_range(0, 1));
        addr_p[p] = AW'($urandom_range(0, NW - 1));
        wd_p[p]   = DW'($urandom_range(0, (1 << DW) - 1));
      end
      if (mode < 2) begin
        n_ops = 1;
        op_p[0] = 1'(mode);
      end else begin
        n_ops = 2;
        op_p[0] = last_b_m ? 1'b0 : 1'b1;
        op_p[1] = !op_p[0];
        drive(1'b0, 1'b1, wr_p[0], addr_p[0], wd_p[0]);
        drive(1'b1, 1'b1, wr_p[1], addr_p[1], wd_p[1]);
      end
      for (int k = 0; k < n_ops; k++) begin
        op_wr[k]   = wr_p[op_p[k]];
        op_addr[k] = addr_p[op_p[k]];
        op_wd[k]   = wd_p[op_p[k]];
        do_op(op_p[k], op_wr[k], op_addr[k], op_wd[k], ok, waited, rv, rd, orv);
        tests++; if (!ok || waited != 0) begin errors++; $display("FAIL rand_gnt[%0d.%0d]: port %0d ok=%b waited=%0d want 1/0", it, k, op_p[k], ok, waited); end
        if (!op_wr[k]) begin
          tests++; if (rv !== 1'b1 || rd !== mem_m[op_addr[k]] || orv !== 1'b0) begin errors++; $display("FAIL rand_read[%0d.%0d]: port %0d addr %0d rvalid=%b rdata=%0d other=%b want 1/%0d/0", it, k, op_p[k], op_addr[k], rv, rd, orv, mem_m[op_addr[k]]); end
        end else begin
          mem_m[op_addr[k]] = op_wd[k];
        end
        last_b_m = op_p[k];
      end
      quiet();
    end
  endtask

  initial begin
    quiet();
    test_reset();
    test_write_read();
    test_round_robin();
    test_clear();
    test_clr_priority();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
